// File: rtl/note_sequencer.sv
// note_sequencer: record/playback controller feeding the buzzer rate divider.
// Records run-length {ascii, duration} entries on a fixed tick and replays them via ascii_out/is_loading.
module note_sequencer #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 100,
   parameter int DEPTH   = 64,
   parameter int ADDR_W  = 6,
   parameter int DUR_W   = 12
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [6:0]        ascii_in,
   input  logic              rec_start,
   input  logic              play_start,
   input  logic              stop,
   output logic [6:0]        ascii_out,
   output logic              is_loading,
   output logic [2:0]        state,
   output logic [ADDR_W:0]   count,
   output logic              full
);
   localparam int PRE = CLK_HZ / TICK_HZ;
   localparam int PW = (PRE > 1) ? $clog2(PRE) : 1;
   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam int EW = 7 + DUR_W;

   typedef enum logic [2:0] {IDLE = 3'd0, REC = 3'd1, LOAD = 3'd2, PLAY = 3'd3} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     pre_q, pre_d;
   logic [6:0]        ascii_q, ascii_d, cur_q, cur_d;
   logic [DUR_W-1:0]  dur_q, dur_d, rem_q, rem_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              full_q, full_d;
   logic              we, tick;
   logic [EW-1:0]     mem [DEPTH];
   logic [EW-1:0]     rd_data_q;

   assign tick = pre_q == '0;

   always_comb begin
      state_d  = state_q;
      ascii_d  = ascii_q;
      cur_d    = cur_q;
      dur_d    = dur_q;
      rem_d    = rem_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      full_d   = full_q;
      we       = 1'b0;
      case (state_q)
         IDLE: begin
            if (stop) begin
            end else if (rec_start) begin
               state_d = REC;
               count_d = '0;
               full_d  = 1'b0;
               cur_d   = ascii_in;
               dur_d   = '0;
            end else if (play_start && count_q != '0) begin
               state_d  = LOAD;
               rd_ptr_d = '0;
            end
         end
         REC: begin
            if (stop) begin
               we      = dur_q != '0 && count_q < DEPTH_C;
               count_d = we ? count_q + 1'b1 : count_q;
               full_d  = count_d == DEPTH_C;
               state_d = IDLE;
            end else if (tick) begin
               // a key change or a saturated duration closes the current run
               if (ascii_in != cur_q || &dur_q) begin
                  we      = dur_q != '0;
                  cur_d   = ascii_in;
                  dur_d   = DUR_W'(1);
                  count_d = we ? count_q + 1'b1 : count_q;
                  if (count_d == DEPTH_C) begin
                     full_d  = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  dur_d = dur_q + 1'b1;
               end
            end
         end
         LOAD: begin
            state_d = stop ? IDLE : PLAY;
            ascii_d = stop ? 7'd0 : rd_data_q[EW-1 -: 7];
            rem_d   = stop ? rem_q : rd_data_q[DUR_W-1:0];
         end
         PLAY: begin
            if (stop) begin
               state_d = IDLE;
               ascii_d = '0;
            end else if (tick) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == DUR_W'(1)) begin
                  if ({1'b0, rd_ptr_q} == count_q - 1'b1) begin
                     state_d = IDLE;
                     ascii_d = '0;
                  end else begin
                     rd_ptr_d = rd_ptr_q + 1'b1;
                     state_d  = LOAD;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            ascii_d = '0;
         end
      endcase
      // reload on every state change so the first tick lands a full period after entry
      pre_d = (state_d != state_q || pre_q == '0) ? PW'(PRE - 1) : pre_q - 1'b1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         pre_q    <= '0;
         ascii_q  <= '0;
         cur_q    <= '0;
         dur_q    <= '0;
         rem_q    <= '0;
         count_q  <= '0;
         rd_ptr_q <= '0;
         full_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pre_q    <= pre_d;
         ascii_q  <= ascii_d;
         cur_q    <= cur_d;
         dur_q    <= dur_d;
         rem_q    <= rem_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         full_q   <= full_d;
      end
   end

   // read address comes from the next pointer so the entry is ready during LOAD
   always_ff @(posedge clk) begin
      if (we) mem[count_q[ADDR_W-1:0]] <= {cur_q, dur_q};
      rd_data_q <= mem[rd_ptr_d];
   end

   assign ascii_out  = ascii_q;
   assign is_loading = state_q == LOAD || state_q == PLAY;
   assign state      = state_q;
   assign count      = count_q;
   assign full       = full_q;
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: table vectors plus randomized recordings checked against a run-length model,
// with playback verified cycle by cycle, and hand sequences for stop/reset/priority corners.
module tb_note_sequencer;
   logic       clk = 1'b0, resetn = 1'b0;
   logic [6:0] ascii_in = '0;
   logic       rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
   logic [6:0] ascii_out;
   logic       is_loading;
   logic [2:0] state;
   logic [2:0] count;
   logic       full;

   int checks = 0, errors = 0;
   int smp[16];
   int qa[$], qd[$];
   int exp_cnt;
   bit exp_full;

   typedef struct packed {
      logic [7:0]   cur0;
      logic [4:0]   n;
      logic [127:0] smp;
      logic [2:0]   cnt;
      logic         full;
      logic [63:0]  ent;
   } vec_t;
   vec_t vt[6];

   always #5 clk = ~clk;

   note_sequencer #(.CLK_HZ(100), .TICK_HZ(10), .DEPTH(4), .ADDR_W(2), .DUR_W(3)) dut (
      .clk(clk), .resetn(resetn), .ascii_in(ascii_in), .rec_start(rec_start),
      .play_start(play_start), .stop(stop), .ascii_out(ascii_out), .is_loading(is_loading),
      .state(state), .count(count), .full(full)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int cv(input logic [7:0] c);
      return (c == 8'h2E) ? 0 : int'(c);
   endfunction

   // expected entries: runs of equal samples, split into chunks of at most 7 ticks, capped at 4 entries
   task automatic model(input int m);
      int ra[$], rl[$];
      qa.delete();
      qd.delete();
      for (int k = 0; k < m; k++) begin
         if (ra.size() > 0 && ra[ra.size()-1] == smp[k]) rl[rl.size()-1] = rl[rl.size()-1] + 1;
         else begin
            ra.push_back(smp[k]);
            rl.push_back(1);
         end
      end
      foreach (ra[i]) begin
         for (int l = rl[i]; l > 0; l -= 7) begin
            qa.push_back(ra[i]);
            qd.push_back(l > 7 ? 7 : l);
         end
      end
      exp_full = qa.size() >= 4;
      while (qa.size() > 4) begin
         void'(qa.pop_back());
         void'(qd.pop_back());
      end
      exp_cnt = qa.size();
   endtask

   task automatic record(input logic [6:0] c0, input int n, input bit col);
      ascii_in = c0;
      rec_start = 1'b1;
      step();
      rec_start = 1'b0;
      for (int k = 0; k < n; k++) begin
         ascii_in = 7'(smp[k]);
         repeat ((col && k == n - 1) ? 9 : 10) step();
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      ascii_in = '0;
      step();
      chk("rec_state", state, 0);
      chk("rec_count", count, exp_cnt);
      chk("rec_full", full, exp_full);
   endtask

   task automatic play_check();
      logic [6:0] prev = '0;
      play_start = 1'b1;
      step();
      play_start = 1'b0;
      if (exp_cnt == 0) begin
         repeat (5) begin
            chk("empty_play", {state, is_loading}, 0);
            step();
         end
         return;
      end
      for (int j = 0; j < exp_cnt; j++) begin
         chk("load", {state, ascii_out, is_loading}, {3'd2, prev, 1'b1});
         step();
         repeat (10 * qd[j]) begin
            chk("play", {state, ascii_out, is_loading}, {3'd3, 7'(qa[j]), 1'b1});
            step();
         end
         prev = 7'(qa[j]);
      end
      chk("play_end", {state, ascii_out, is_loading}, 0);
      chk("play_count", count, exp_cnt);
   endtask

   task automatic run_vec(input vec_t v);
      int m;
      m = int'(v.cnt);
      for (int k = 0; k < int'(v.n); k++) smp[k] = cv(v.smp[8*(int'(v.n)-1-k) +: 8]);
      qa.delete();
      qd.delete();
      for (int j = 0; j < m; j++) begin
         qa.push_back(cv(v.ent[8*(2*(m-j)-1) +: 8]));
         qd.push_back(int'(v.ent[8*(2*(m-j)-2) +: 8]) - 48);
      end
      exp_cnt = m;
      exp_full = v.full;
      record(7'(cv(v.cur0)), int'(v.n), 1'b0);
      play_check();
   endtask

   initial begin
      vt[0] = '{8'h41, 5'd5, 128'("AAASS"),     3'd2, 1'b0, 64'("A3S2")};
      vt[1] = '{8'h41, 5'd9, 128'("AAAAAAAAA"), 3'd2, 1'b0, 64'("A7A2")};
      vt[2] = '{8'h41, 5'd6, 128'("ASASAS"),    3'd4, 1'b1, 64'("A1S1A1S1")};
      vt[3] = '{8'h2E, 5'd4, 128'(".A.."),      3'd3, 1'b0, 64'(".1A1.2")};
      vt[4] = '{8'h53, 5'd2, 128'("AA"),        3'd1, 1'b0, 64'("A2")};
      vt[5] = '{8'h41, 5'd0, 128'(0),           3'd0, 1'b0, 64'(0)};

      repeat (3) step();
      chk("reset_out", {state, ascii_out, is_loading}, 0);
      chk("reset_count", count, 0);
      chk("reset_full", full, 0);
      resetn = 1'b1;
      step();

      for (int i = 0; i < 6; i++) run_vec(vt[i]);

      for (int r = 0; r < 12; r++) begin
         int n;
         bit col;
         n = $urandom_range(1, 12);
         col = $urandom_range(0, 3) == 0;
         for (int k = 0; k < n; k++) begin
            int pick;
            pick = $urandom_range(0, 2);
            smp[k] = (k > 0 && $urandom_range(0, 9) < 6) ? smp[k-1] : (pick == 0 ? 0 : pick == 1 ? 65 : 83);
         end
         model(col ? n - 1 : n);
         record(7'(65), n, col);
         play_check();
      end

      run_vec(vt[0]);
      ascii_in = 7'd65;
      rec_start = 1'b1;
      play_start = 1'b1;
      step();
      rec_start = 1'b0;
      play_start = 1'b0;
      chk("rec_over_play", state, 1);
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("empty_rec_count", {state, count}, 0);

      run_vec(vt[0]);
      play_start = 1'b1;
      step();
      play_start = 1'b0;
      repeat (15) step();
      chk("mid_play", {state, ascii_out, is_loading}, {3'd3, 7'd65, 1'b1});
      stop = 1'b1;
      step();
      stop = 1'b0;
      chk("stop_play", {state, ascii_out, is_loading}, 0);
      chk("stop_play_count", count, 2);

      play_start = 1'b1;
      step();
      play_start = 1'b0;
      repeat (35) step();
      chk("pre_reset", {state, ascii_out, is_loading}, {3'd3, 7'd83, 1'b1});
      resetn = 1'b0;
      #1;
      chk("async_reset", {state, ascii_out, is_loading}, 0);
      chk("async_reset_count", count, 0);
      step();
      resetn = 1'b1;
      step();
      chk("after_reset", {state, count, full}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Record/playback controller for the buzzer rate divider.
- In record mode it samples the live key code on a fixed time tick and run-length encodes it into an internal buffer of {ascii, duration} entries.
- In play mode it replays the buffer by driving ascii_out and is_loading into the saved-buzzer divider, so the divider itself is unchanged.
- Sits between the PS/2 key decoder and rate_divider_for_load.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 100, sample/playback tick rate (10 ms at default).
- DEPTH, 64, number of buffer entries.
- ADDR_W, 6, log2(DEPTH).
- DUR_W, 12, duration field width, in ticks.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- ascii_in  in  7  live key code; 0 = no key (rest).
- rec_start  in  1  single-cycle pulse; starts recording.
- play_start  in  1  single-cycle pulse; starts playback.
- stop  in  1  single-cycle pulse; ends record or play.
- ascii_out  out  7  key code to the divider.
- is_loading  out  1  high while playback is active.
- state  out  3  current FSM state encoding.
- count  out  ADDR_W+1  number of valid entries.
- full  out  1  sticky flag: buffer filled during the last recording.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; ascii_out=0; is_loading=0; count=0; full=0.
  - Internal pointers, duration and prescaler cleared. Buffer contents are not reset.
- Tick generator:
  - Prescaler counts CLK_HZ/TICK_HZ-1 down to 0, then reloads.
  - tick is a 1-cycle pulse at 0.
  - Prescaler reloads on any state entry, so the first tick arrives exactly CLK_HZ/TICK_HZ cycles after entry.
- Command priority: stop > rec_start > play_start.
  - Starts are accepted only in IDLE; they are ignored elsewhere.
  - stop in IDLE is a no-op.
- States:
  - IDLE: ascii_out=0; is_loading=0.
    - rec_start -> REC: count=0, full=0, cur=ascii_in, dur=0.
    - play_start -> LOAD, rd_ptr=0, if count!=0. If count==0, stay in IDLE.
  - REC: ascii_out=0; is_loading=0. On tick:
    - If ascii_in!=cur, or dur==2^DUR_W-1:
      - If dur!=0, write {cur,dur} at count, then count++.
      - Then cur=ascii_in, dur=1.
    - Otherwise dur++.
    - Rests (ascii 0) are recorded like any other key.
    - After a write that makes count==DEPTH: full=1, go to IDLE. The pending sample is discarded.
  - REC + stop: if dur!=0 and count<DEPTH, write {cur,dur} and count++. Go to IDLE on the next cycle.
  - LOAD: one cycle, for the registered buffer read at rd_ptr.
    - Next cycle: ascii_out=entry.ascii, rem=entry.dur, go to PLAY.
    - is_loading=1 from LOAD onward.
  - PLAY: ascii_out holds the entry code; is_loading=1. On tick, rem--.
    - When rem reaches 0 and rd_ptr==count-1: go to IDLE. ascii_out=0 and is_loading=0 on the same edge.
    - When rem reaches 0 otherwise: rd_ptr++, go to LOAD. ascii_out keeps its old value during LOAD.
  - LOAD/PLAY + stop: IDLE on the next edge; ascii_out=0; is_loading=0.
- Timing result: entry i is audible for dur_i ticks, plus one clk per LOAD. Total drift is count cycles, which is acceptable.
- Widths:
  - dur saturates by splitting into a new entry with the same code, never by wrapping.
  - count is ADDR_W+1 bits so it can represent DEPTH.
- Simultaneous events:
  - tick and stop in the same cycle in REC: the stop flush path is taken; the tick sample is ignored.
  - tick and stop in the same cycle in PLAY: stop wins.
- Reset mid-operation: immediate return to the reset values above. The recording is lost (count=0).
- state encoding: IDLE=0, REC=1, LOAD=2, PLAY=3. Values 4-7 are unused and recover to IDLE.

Test Plan:
- CLK_HZ=100, TICK_HZ=10 (tick every 10 clk). rec_start, hold ascii_in=65 for 3 ticks, then 83 for 2 ticks, then stop -> count=2; entries {65,3},{83,2}; state=IDLE.
- play_start after the previous scenario -> is_loading=1; ascii_out=65 for 30 clk (+1 LOAD), then 83 for 20 clk; then ascii_out=0, is_loading=0, state=IDLE.
- DUR_W=3, hold 65 for 9 ticks then stop -> entries {65,7},{65,2}; count=2.
- DEPTH=4, ascii_in alternates 65/83 every tick -> after the 4th write: state=IDLE, full=1, count=4. A later rec_start clears full.
- Empty buffer (count=0), play_start -> state stays IDLE; is_loading never rises. rec_start and play_start in the same cycle -> REC.
- resetn low for 1 clk during PLAY -> ascii_out=0, is_loading=0, count=0 immediately. stop during PLAY -> IDLE on the next edge.
